// File: rtl/cve2_pkg.sv
// Shared ALU operator encoding used by the stimulus generator.
package cve2_pkg;

    typedef enum logic [6:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SRA,
        ALU_SRL,
        ALU_SLL,
        ALU_LT,
        ALU_LTU,
        ALU_GE,
        ALU_GEU,
        ALU_EQ,
        ALU_NE,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

endpackage

// File: rtl/cve2_alu_stim_gen.sv
// Pseudo-random ALU stimulus generator: two Galois LFSRs drive operator and
// operands through a valid/ready handshake, with periodic corner operands.
// Optional macro CVE2_STIM_MULTDIV_EN adds two-beat multdiv vectors.
module cve2_alu_stim_gen
    import cve2_pkg::*;
#(
    parameter logic [31:0] LFSR_TAPS     = 32'hA3000000,
    parameter int unsigned CORNER_PERIOD = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [15:0]   num_vectors_i,
    input  logic [31:0]   seed_i,
    input  logic          ready_i,
    output logic          valid_o,
    output alu_op_e       operator_o,
    output logic [31:0]   operand_a_o,
    output logic [31:0]   operand_b_o,
    output logic          instr_first_cycle_o,
    output logic [32:0]   multdiv_operand_a_o,
    output logic [32:0]   multdiv_operand_b_o,
    output logic          multdiv_sel_o,
    output logic [31:0]   imd_val0_o,
    output logic [31:0]   imd_val1_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   vec_count_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CORNER_MASK = CNT_W'(CORNER_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        HOLD2,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  lfsr_a_q, lfsr_a_d;
    logic [DATA_W-1:0]  lfsr_b_q, lfsr_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic               busy_c;
    logic               accept_c;
    logic               final_beat_c;
    logic               vec_valid_c;
    logic               corner_c;
    logic [DATA_W-1:0]  opa_c;
    logic [DATA_W-1:0]  opb_c;
    alu_op_e            op_c;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [DATA_W-1:0] corner_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return 32'h0000_0000;
            2'd1:    return 32'hFFFF_FFFF;
            2'd2:    return 32'h8000_0000;
            default: return 32'h7FFF_FFFF;
        endcase
    endfunction

    function automatic alu_op_e op_sel(input logic [3:0] idx);
        case (idx)
            4'd0:    return ALU_ADD;
            4'd1:    return ALU_SUB;
            4'd2:    return ALU_XOR;
            4'd3:    return ALU_OR;
            4'd4:    return ALU_AND;
            4'd5:    return ALU_SRA;
            4'd6:    return ALU_SRL;
            4'd7:    return ALU_SLL;
            4'd8:    return ALU_LT;
            4'd9:    return ALU_LTU;
            4'd10:   return ALU_GE;
            4'd11:   return ALU_GEU;
            4'd12:   return ALU_EQ;
            4'd13:   return ALU_NE;
            4'd14:   return ALU_SLT;
            default: return ALU_SLTU;
        endcase
    endfunction

    assign busy_c   = (state_q == GEN) || (state_q == HOLD2);
    assign accept_c = busy_c && ready_i;

    // State register plus LFSRs, vector counter and latched run length
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lfsr_a_q <= 32'h1;
            lfsr_b_q <= 32'h1;
            cnt_q    <= '0;
            num_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
        end
    end

    // Next-state logic: run start, beat acceptance, vector completion and abort
    always_comb begin
        state_d      = state_q;
        lfsr_a_d     = lfsr_a_q;
        lfsr_b_d     = lfsr_b_q;
        cnt_d        = cnt_q;
        num_d        = num_q;
        final_beat_c = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    num_d    = num_vectors_i;
                    cnt_d    = '0;
                    lfsr_a_d = (seed_i == '0) ? 32'h1 : seed_i;
                    lfsr_b_d = (seed_i == '1) ? 32'h1 : ~seed_i;
                    state_d  = (num_vectors_i == '0) ? DONE : GEN;
                end
            end
            GEN: begin
                if (accept_c) begin
`ifdef CVE2_STIM_MULTDIV_EN
                    if (lfsr_a_q[6]) begin
                        state_d = HOLD2;
                    end else begin
                        final_beat_c = 1'b1;
                    end
`else
                    final_beat_c = 1'b1;
`endif
                end
            end
            HOLD2: begin
                final_beat_c = accept_c;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completed vector counts and advances both LFSRs exactly once
        if (final_beat_c) begin
            cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            lfsr_a_d = lfsr_step(lfsr_a_q);
            lfsr_b_d = lfsr_step(lfsr_b_q);
            state_d  = (cnt_d == num_q) ? DONE : GEN;
        end

        if (busy_c && stop_i) begin
            state_d = DONE;
        end
    end

    // Vector contents for the upcoming beat, derived from next-state values
    always_comb begin
        vec_valid_c = (state_d == GEN) || (state_d == HOLD2);
        corner_c    = (cnt_d & CORNER_MASK) == CORNER_MASK;
        opa_c       = corner_c ? corner_val(lfsr_a_d[5:4]) : lfsr_a_d;
        opb_c       = corner_c ? corner_val(lfsr_b_d[5:4]) : lfsr_b_d;
        op_c        = op_sel(lfsr_a_d[3:0]);
    end

    // Registered handshake, status and base vector outputs; held while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            operator_o  <= ALU_ADD;
            operand_a_o <= '0;
            operand_b_o <= '0;
        end else begin
            valid_o <= vec_valid_c;
            busy_o  <= vec_valid_c;
            done_o  <= (state_d == DONE);
            if (vec_valid_c) begin
                operator_o  <= op_c;
                operand_a_o <= opa_c;
                operand_b_o <= opb_c;
            end
        end
    end

    assign vec_count_o = cnt_q;

`ifdef CVE2_STIM_MULTDIV_EN
    logic               md_c;
    logic               beat2_c;
    logic [DATA_W-1:0]  imd0_c;
    logic [DATA_W-1:0]  imd1_c;

    // Multdiv beat decoration: second beat carries sum and xor of the operands
    always_comb begin
        md_c    = lfsr_a_d[6];
        beat2_c = (state_d == HOLD2);
        imd0_c  = beat2_c ? opa_c + opb_c : '0;
        imd1_c  = beat2_c ? opa_c ^ opb_c : '0;
    end

    // Registered multdiv outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            multdiv_sel_o       <= 1'b0;
            multdiv_operand_a_o <= '0;
            multdiv_operand_b_o <= '0;
            instr_first_cycle_o <= 1'b1;
            imd_val0_o          <= '0;
            imd_val1_o          <= '0;
        end else if (vec_valid_c) begin
            multdiv_sel_o       <= md_c;
            multdiv_operand_a_o <= md_c ? {opa_c[31], opa_c} : '0;
            multdiv_operand_b_o <= md_c ? {opb_c[31], opb_c} : '0;
            instr_first_cycle_o <= ~beat2_c;
            imd_val0_o          <= imd0_c;
            imd_val1_o          <= imd1_c;
        end
    end
`else
    assign multdiv_sel_o       = 1'b0;
    assign multdiv_operand_a_o = '0;
    assign multdiv_operand_b_o = '0;
    assign instr_first_cycle_o = 1'b1;
    assign imd_val0_o          = '0;
    assign imd_val1_o          = '0;
`endif

endmodule
